// File: rtl/trade_pkg.sv
// Shared types for the streaming trade advisor: trend classes, action codes
// and the controller state encoding.
package trade_pkg;

  typedef enum logic [2:0] {
    STAGNANT    = 3'd0,
    STRONG_UP   = 3'd1,
    STRONG_DOWN = 3'd2,
    MILD_UP     = 3'd3,
    MILD_DOWN   = 3'd4
  } trend_e;

  localparam logic [3:0] ACT_FAILED      = 4'd0;
  localparam logic [3:0] ACT_SELL_ALL    = 4'd1;
  localparam logic [3:0] ACT_STAY_OUT    = 4'd2;
  localparam logic [3:0] ACT_BUY_MORE    = 4'd3;
  localparam logic [3:0] ACT_BUY_A_LOT   = 4'd4;
  localparam logic [3:0] ACT_SELL_HALF   = 4'd5;
  localparam logic [3:0] ACT_BUY_LT_MORE = 4'd6;
  localparam logic [3:0] ACT_BUY_LITTLE  = 4'd7;
  localparam logic [3:0] ACT_HOLD        = 4'd8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EVAL = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Map a trend class plus ownership onto the action code; unknown trends fail.
  function automatic logic [3:0] action_code(input logic [2:0] trend, input logic owned);
    logic [3:0] code;
    case (trend)
      STRONG_UP:   code = owned ? ACT_SELL_ALL  : ACT_STAY_OUT;
      STRONG_DOWN: code = owned ? ACT_BUY_MORE  : ACT_BUY_A_LOT;
      MILD_UP:     code = owned ? ACT_SELL_HALF : ACT_STAY_OUT;
      MILD_DOWN:   code = owned ? ACT_BUY_LT_MORE : ACT_BUY_LITTLE;
      STAGNANT:    code = owned ? ACT_HOLD      : ACT_BUY_LITTLE;
      default:     code = ACT_FAILED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/trend_classifier.sv
// Combinational trend classifier over a packed price window (oldest sample in
// the lowest slice) with a stagnation threshold, plus the action code lookup.
module trend_classifier
  import trade_pkg::*;
#(
  parameter int PRICE_W = 5,
  parameter int WINDOW  = 3,
  parameter int ACT_W   = 16
) (
  input  logic [PRICE_W*WINDOW-1:0] window_i,
  input  logic [PRICE_W-1:0]        thresh_i,
  input  logic                      owned_i,
  output logic [2:0]                trend_o,
  output logic [ACT_W-1:0]          code_o
);

  logic [WINDOW-2:0] rise_vec;
  logic [WINDOW-2:0] fall_vec;
  logic [PRICE_W-1:0] oldest;
  logic [PRICE_W-1:0] newest;
  logic signed [PRICE_W:0] delta;
  logic signed [PRICE_W:0] thr_pos;
  logic signed [PRICE_W:0] thr_neg;

  // One rise/fall flag per consecutive pair; equal pairs set neither.
  for (genvar gi = 0; gi < WINDOW - 1; gi++) begin : g_pair
    logic [PRICE_W-1:0] p_lo;
    logic [PRICE_W-1:0] p_hi;
    assign p_lo         = window_i[gi*PRICE_W +: PRICE_W];
    assign p_hi         = window_i[(gi+1)*PRICE_W +: PRICE_W];
    assign rise_vec[gi] = (p_hi > p_lo);
    assign fall_vec[gi] = (p_hi < p_lo);
  end

  assign oldest  = window_i[0 +: PRICE_W];
  assign newest  = window_i[(WINDOW-1)*PRICE_W +: PRICE_W];
  assign delta   = $signed({1'b0, newest}) - $signed({1'b0, oldest});
  assign thr_pos = $signed({1'b0, thresh_i});
  assign thr_neg = -thr_pos;

  // Strong classes (every pair moving the same way) win over the threshold test.
  always_comb begin
    trend_o = STAGNANT;
    if (&rise_vec)             trend_o = STRONG_UP;
    else if (&fall_vec)        trend_o = STRONG_DOWN;
    else if (delta > thr_pos)  trend_o = MILD_UP;
    else if (delta < thr_neg)  trend_o = MILD_DOWN;
    code_o = ACT_W'(action_code(trend_o, owned_i));
  end

endmodule

// File: rtl/trade_advisor_stream.sv
// Streaming trade advisor: collects WINDOW price samples, classifies the
// trend for one cycle, then holds the decision on a valid/ready output.
module trade_advisor_stream
  import trade_pkg::*;
#(
  parameter int PRICE_W = 5,
  parameter int WINDOW  = 3,
  parameter int ACT_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PRICE_W-1:0] price_in,
  input  logic               owned_in,
  input  logic [PRICE_W-1:0] thresh_in,
  input  logic               sliding_in,
  input  logic               clr,
  output logic               act_valid,
  input  logic               act_ready,
  output logic [ACT_W-1:0]   act_code,
  output logic [2:0]         act_trend,
  output logic [CNT_W-1:0]   decision_cnt
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

  state_e             state_q;
  logic [CW-1:0]      count_q;
  logic               owned_q;
  logic               clr_pend_q;
  logic               act_valid_q;
  logic [ACT_W-1:0]   code_q;
  logic [2:0]         trend_q;
  logic [CNT_W-1:0]   dcnt_q;
  logic [PRICE_W-1:0] win_q [WINDOW];

  logic [PRICE_W*WINDOW-1:0] win_flat;
  logic [2:0]                cls_trend;
  logic [ACT_W-1:0]          cls_code;
  logic                      accept;

  // A sample presented together with clr is dropped rather than stored.
  assign in_ready = (state_q == ST_FILL) && !rst;
  assign accept   = in_valid && in_ready && !clr;

  // Window shift register: newest sample enters at the top index.
  for (genvar gi = 0; gi < WINDOW; gi++) begin : g_win
    if (gi == WINDOW - 1) begin : g_top
      always_ff @(posedge clk) begin
        if (accept) win_q[gi] <= price_in;
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (accept) win_q[gi] <= win_q[gi+1];
      end
    end
    assign win_flat[gi*PRICE_W +: PRICE_W] = win_q[gi];
  end

  trend_classifier #(
    .PRICE_W (PRICE_W),
    .WINDOW  (WINDOW),
    .ACT_W   (ACT_W)
  ) u_cls (
    .window_i (win_flat),
    .thresh_i (thresh_in),
    .owned_i  (owned_q),
    .trend_o  (cls_trend),
    .code_o   (cls_code)
  );

  // Controller FSM with registered decision outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      owned_q     <= 1'b0;
      clr_pend_q  <= 1'b0;
      act_valid_q <= 1'b0;
      code_q      <= '0;
      trend_q     <= '0;
      dcnt_q      <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (clr) begin
            count_q <= '0;
          end else if (accept) begin
            owned_q <= owned_in;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_IDX) state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (clr) begin
            // Abort: nothing is emitted and the window starts over.
            count_q <= '0;
            state_q <= ST_FILL;
          end else begin
            trend_q     <= cls_trend;
            code_q      <= cls_code;
            act_valid_q <= 1'b1;
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (act_ready) begin
            act_valid_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            state_q     <= ST_FILL;
            if (dcnt_q != {CNT_W{1'b1}}) dcnt_q <= dcnt_q + 1'b1;
            // A clr seen during EMIT empties the window even in sliding mode.
            if (sliding_in && !clr && !clr_pend_q) count_q <= LAST_IDX;
            else                                   count_q <= '0;
          end else if (clr) begin
            clr_pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_FILL;
          count_q <= '0;
        end
      endcase
    end
  end

  assign act_valid    = act_valid_q;
  assign act_code     = code_q;
  assign act_trend    = trend_q;
  assign decision_cnt = dcnt_q;

endmodule

// File: tb/tb_trade_advisor_stream.sv
// Scoreboard bench for trade_advisor_stream: stimulus pushes expected
// decisions, a negedge monitor pops and compares on each output handshake.
module tb_trade_advisor_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  price_in;
  logic        owned_in;
  logic [4:0]  thresh_in;
  logic        sliding_in;
  logic        clr;
  logic        act_valid;
  logic        act_ready;
  logic [15:0] act_code;
  logic [2:0]  act_trend;
  logic [15:0] decision_cnt;

  typedef struct {
    logic [2:0]  trend;
    logic [15:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   dec_seen = 0;

  always #5 clk = ~clk;

  trade_advisor_stream dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .price_in     (price_in),
    .owned_in     (owned_in),
    .thresh_in    (thresh_in),
    .sliding_in   (sliding_in),
    .clr          (clr),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act_code     (act_code),
    .act_trend    (act_trend),
    .decision_cnt (decision_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every completed output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && act_valid && act_ready) begin
      dec_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_decision: got trend %0d code %0d, expected none",
                 act_trend, act_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("trend", 32'(act_trend), 32'(e.trend));
        chk("code", 32'(act_code), 32'(e.code));
        $display("[TB] decision %0d: trend %0d code %0d", dec_seen, act_trend, act_code);
      end
    end
  end

  task automatic push_exp(input logic [2:0] t, input logic [15:0] c);
    exp_t e;
    e.trend = t;
    e.code  = c;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [4:0] p, input logic o);
    int n;
    n = 0;
    @(negedge clk);
    price_in = p;
    owned_in = o;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic o);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, o);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || act_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || act_valid) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!act_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("act_valid_wait", 32'(act_valid), 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; price_in = '0; owned_in = 1'b0;
    thresh_in = '0; sliding_in = 1'b0; clr = 1'b0; act_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_act_valid", 32'(act_valid), 32'd0);
    chk("rst_act_code", 32'(act_code), 32'd0);
    chk("rst_act_trend", 32'(act_trend), 32'd0);
    chk("rst_decision_cnt", 32'(decision_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("fill_in_ready", 32'(in_ready), 32'd1);

    // Block mode, strong up, owned: also check the two-cycle latency.
    push_exp(3'd1, 16'd1);
    send3(5'd3, 5'd5, 5'd9, 1'b1);
    chk("lat_t0_valid", 32'(act_valid), 32'd0);
    chk("eval_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("lat_t2_valid", 32'(act_valid), 32'd1);
    wait_idle();
    chk("cnt_after_1", 32'(decision_cnt), 32'd1);

    // Strong down not owned, then flat owned.
    push_exp(3'd2, 16'd4);
    send3(5'd9, 5'd5, 5'd3, 1'b0);
    push_exp(3'd0, 16'd8);
    send3(5'd4, 5'd4, 5'd4, 1'b1);
    wait_idle();

    // Threshold boundaries: delta 3 > 2 is mild up; delta 1 stays stagnant.
    thresh_in = 5'd2;
    push_exp(3'd3, 16'd5);
    send3(5'd5, 5'd2, 5'd8, 1'b1);
    push_exp(3'd0, 16'd7);
    send3(5'd5, 5'd2, 5'd6, 1'b0);
    wait_idle();
    chk("cnt_after_5", 32'(decision_cnt), 32'd5);

    // Sliding mode: 1,2,3,4,2 -> three overlapping windows.
    thresh_in = 5'd0;
    sliding_in = 1'b1;
    push_exp(3'd1, 16'd2);
    push_exp(3'd1, 16'd2);
    push_exp(3'd4, 16'd7);
    send3(5'd1, 5'd2, 5'd3, 1'b0);
    send(5'd4, 1'b0);
    send(5'd2, 1'b0);
    wait_idle();
    sliding_in = 1'b0;
    pulse_clr();
    chk("cnt_after_slide", 32'(decision_cnt), 32'd8);

    // Backpressure: decision held stable, no samples accepted.
    act_ready = 1'b0;
    push_exp(3'd1, 16'd1);
    send3(5'd3, 5'd5, 5'd9, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(act_valid), 32'd1);
      chk("bp_code", 32'(act_code), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    act_ready = 1'b1;
    wait_idle();
    chk("cnt_after_bp", 32'(decision_cnt), 32'd9);

    // Reset during EMIT drops the pending decision immediately.
    act_ready = 1'b0;
    send3(5'd9, 5'd5, 5'd3, 1'b0);
    wait_valid();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_emit_valid", 32'(act_valid), 32'd0);
    chk("rst_emit_cnt", 32'(decision_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    act_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // clr after two samples: only the three new samples form a window.
    send(5'd9, 1'b0);
    send(5'd9, 1'b0);
    pulse_clr();
    push_exp(3'd1, 16'd1);
    send3(5'd1, 5'd2, 5'd3, 1'b1);
    wait_idle();
    chk("cnt_after_clr", 32'(decision_cnt), 32'd1);

    // clr during EVAL aborts the decision and empties the window.
    send3(5'd9, 5'd5, 5'd3, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("eval_clr_valid", 32'(act_valid), 32'd0);
    chk("eval_clr_in_ready", 32'(in_ready), 32'd1);
    push_exp(3'd0, 16'd8);
    send3(5'd4, 5'd4, 5'd4, 1'b1);
    wait_idle();
    chk("cnt_final", 32'(decision_cnt), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
